// File: rtl/doodle_pkg.sv
// doodle_pkg
// Shared constants for the Doodle game datapath: one-hot FSM encodings for
// the jump controller, screen geometry, and default jump/scroll tuning that
// the platform and render blocks reuse.
package doodle_pkg;

  // One-hot jump controller states.
  localparam logic [3:0] ST_I    = 4'b0001;
  localparam logic [3:0] ST_UP   = 4'b0010;
  localparam logic [3:0] ST_DOWN = 4'b0100;
  localparam logic [3:0] ST_DONE = 4'b1000;

  // Screen geometry.
  localparam int V_RES    = 480;
  localparam int H_RES    = 640;
  localparam int DOODLE_H = 20;

  // Default motion tuning.
  localparam int DEF_JUMP_HEIGHT = 120;
  localparam int DEF_SCROLL_LINE = 240;
  localparam int DEF_START_Y     = 440;
  localparam int DEF_FLOOR_Y     = V_RES - DOODLE_H;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/doodle_alt_tracker.sv
// doodle_alt_tracker
// Holds the doodle's current altitude and the best altitude reached this
// game. Altitude counts up/down by one per strobe, saturating at both ends;
// score follows the running maximum of altitude.
//   Clk, Reset : clock, asynchronous active-high reset
//   clr        : zero altitude and score (start of game)
//   inc, dec   : altitude +1 / -1 strobes (inc wins if both are set)
//   score      : maximum altitude since the last clr
module doodle_alt_tracker #(
  parameter int SCORE_W = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               clr,
  input  logic               inc,
  input  logic               dec,
  output logic [SCORE_W-1:0] score
);

  localparam logic [SCORE_W-1:0] ALT_MAX = '1;

  logic [SCORE_W-1:0] alt;
  logic [SCORE_W-1:0] alt_up;
  logic [SCORE_W-1:0] alt_dn;

  always_comb begin
    alt_up = (alt == ALT_MAX) ? alt : alt + SCORE_W'(1);
    alt_dn = (alt == '0)      ? alt : alt - SCORE_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      alt   <= '0;
      score <= '0;
    end else if (clr) begin
      alt   <= '0;
      score <= '0;
    end else if (inc) begin
      alt <= alt_up;
      if (alt_up > score) score <= alt_up;
    end else if (dec) begin
      alt <= alt_dn;
    end
  end

endmodule

// File: rtl/doodle_jump_ctrl.sv
// doodle_jump_ctrl
// Frame-rate jump controller. Once per Tick the doodle rises (UP) or falls
// (DOWN); a platform hit while falling starts a new jump. Rise that would
// take the doodle above the scroll line is converted into world-scroll
// pulses. A fall reaching the floor ends the game (DONE) until Ack.
//   Clk, Reset      : clock, asynchronous active-high reset
//   Start, Ack      : level controls, leave I / leave DONE
//   Tick            : one-cycle frame pulse qualifying all motion
//   plat_hit        : per-platform collision flags, valid on Tick
//   doodle_y        : current doodle top row
//   score           : maximum altitude reached this game
//   scroll_en       : one-cycle pulse, world moves down one pixel
//   q_I..q_Done     : one-hot state
module doodle_jump_ctrl
  import doodle_pkg::*;
#(
  parameter int Y_W         = 10,
  parameter int SCORE_W     = 16,
  parameter int NUM_PLAT    = 4,
  parameter int JUMP_HEIGHT = DEF_JUMP_HEIGHT,
  parameter int START_Y     = DEF_START_Y,
  parameter int FLOOR_Y     = DEF_FLOOR_Y,
  parameter int SCROLL_LINE = DEF_SCROLL_LINE
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Start,
  input  logic                Ack,
  input  logic                Tick,
  input  logic [NUM_PLAT-1:0] plat_hit,
  output logic [Y_W-1:0]      doodle_y,
  output logic [SCORE_W-1:0]  score,
  output logic                scroll_en,
  output logic                q_I,
  output logic                q_Up,
  output logic                q_Down,
  output logic                q_Done
);

  // The rise counter must reach JUMP_HEIGHT even when the score is narrow.
  localparam int RISE_W = max_int(SCORE_W, $clog2(JUMP_HEIGHT + 1));

  localparam logic [Y_W-1:0]    START_YV  = Y_W'(START_Y);
  localparam logic [Y_W-1:0]    FLOOR_YV  = Y_W'(FLOOR_Y);
  localparam logic [Y_W-1:0]    SCROLL_YV = Y_W'(SCROLL_LINE);
  localparam logic [RISE_W-1:0] RISE_TOP  = RISE_W'(JUMP_HEIGHT);

  logic [3:0]        state;
  logic [3:0]        state_next;
  logic [RISE_W-1:0] rise;
  logic [RISE_W-1:0] rise_next;
  logic [Y_W-1:0]    y_next;
  logic              scroll_next;
  logic              alt_clr;
  logic              alt_inc;
  logic              alt_dec;

  logic at_apex;
  logic at_floor;
  logic bounce;

  assign at_apex  = (rise == RISE_TOP);
  assign at_floor = (doodle_y >= FLOOR_YV);
  assign bounce   = |plat_hit;

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= ST_I;
    else       state <= state_next;
  end

  // Next-state logic. Start/Ack act without a Tick; motion needs one.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = ST_I;  // any illegal encoding falls back to I
    case (state)
      ST_I:    state_next = Start ? ST_UP : ST_I;
      ST_UP:   state_next = (Tick && at_apex) ? ST_DOWN : ST_UP;
      ST_DOWN: begin
        if (Tick && bounce)        state_next = ST_UP;
        else if (Tick && at_floor) state_next = ST_DONE;
        else                       state_next = ST_DOWN;
      end
      ST_DONE: state_next = Ack ? ST_I : ST_DONE;
      default: state_next = ST_I;
    endcase
  end

  // Datapath control for the current state.
  always_comb begin
    y_next      = doodle_y;
    rise_next   = rise;
    scroll_next = 1'b0;
    alt_clr     = 1'b0;
    alt_inc     = 1'b0;
    alt_dec     = 1'b0;
    case (state)
      ST_I: begin
        y_next = START_YV;
        if (Start) begin
          rise_next = '0;
          alt_clr   = 1'b1;
        end
      end
      ST_UP: begin
        // The apex tick only changes state; plat_hit is ignored while rising.
        if (Tick && !at_apex) begin
          rise_next = rise + RISE_W'(1);
          alt_inc   = 1'b1;
          if (doodle_y > SCROLL_YV) y_next = doodle_y - Y_W'(1);
          else                      scroll_next = 1'b1;
        end
      end
      ST_DOWN: begin
        if (Tick) begin
          if (bounce) begin
            rise_next = '0;
          end else if (!at_floor) begin
            y_next  = doodle_y + Y_W'(1);
            alt_dec = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (Ack) y_next = START_YV;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      doodle_y  <= START_YV;
      rise      <= '0;
      scroll_en <= 1'b0;
    end else begin
      doodle_y  <= y_next;
      rise      <= rise_next;
      scroll_en <= scroll_next;
    end
  end

  doodle_alt_tracker #(
    .SCORE_W(SCORE_W)
  ) u_alt (
    .Clk   (Clk),
    .Reset (Reset),
    .clr   (alt_clr),
    .inc   (alt_inc),
    .dec   (alt_dec),
    .score (score)
  );

  // One-hot state straight from the state register.
  assign q_I    = (state == ST_I);
  assign q_Up   = (state == ST_UP);
  assign q_Down = (state == ST_DOWN);
  assign q_Done = (state == ST_DONE);

endmodule

// File: tb/tb_doodle_jump_ctrl.sv
module tb_doodle_jump_ctrl;

  localparam int JH    = 120;
  localparam int SY    = 440;
  localparam int FY    = 460;
  localparam int SL    = 240;
  localparam int SMAX  = 65535;

  logic        Clk = 1'b0;
  logic        Reset, Start, Ack, Tick;
  logic [3:0]  plat_hit;
  logic [9:0]  doodle_y;
  logic [15:0] score;
  logic        scroll_en, q_I, q_Up, q_Down, q_Done;

  // Narrow-score instance for the saturation scenario.
  logic        s_start, s_ack, s_tick;
  logic [3:0]  s_hit;
  logic [9:0]  s_y;
  logic [3:0]  s_score;
  logic        s_scroll, s_qi, s_qu, s_qd, s_qe;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  doodle_jump_ctrl dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack), .Tick(Tick),
    .plat_hit(plat_hit), .doodle_y(doodle_y), .score(score),
    .scroll_en(scroll_en), .q_I(q_I), .q_Up(q_Up), .q_Down(q_Down),
    .q_Done(q_Done)
  );

  doodle_jump_ctrl #(.SCORE_W(4), .JUMP_HEIGHT(20)) dut_sat (
    .Clk(Clk), .Reset(Reset), .Start(s_start), .Ack(s_ack), .Tick(s_tick),
    .plat_hit(s_hit), .doodle_y(s_y), .score(s_score),
    .scroll_en(s_scroll), .q_I(s_qi), .q_Up(s_qu), .q_Down(s_qd),
    .q_Done(s_qe)
  );

  // Reference model: game phase plus plain integer quantities.
  typedef enum {M_IDLE, M_RISE, M_FALL, M_OVER} phase_t;
  phase_t m_ph;
  int     m_y, m_rise, m_alt, m_score;
  bit     m_scroll;

  function automatic logic [3:0] exp_q(input phase_t ph);
    case (ph)
      M_IDLE:  return 4'b1000;
      M_RISE:  return 4'b0100;
      M_FALL:  return 4'b0010;
      default: return 4'b0001;
    endcase
  endfunction

  task automatic model_reset();
    m_ph = M_IDLE; m_y = SY; m_rise = 0; m_alt = 0; m_score = 0; m_scroll = 0;
  endtask

  task automatic model_update(input bit st, input bit ack, input bit tk,
                              input logic [3:0] hit);
    m_scroll = 0;
    case (m_ph)
      M_IDLE: begin
        m_y = SY;
        if (st) begin
          m_ph = M_RISE; m_rise = 0; m_alt = 0; m_score = 0;
        end
      end
      M_RISE: if (tk) begin
        if (m_rise == JH) m_ph = M_FALL;
        else begin
          m_rise++;
          if (m_alt < SMAX) m_alt++;
          if (m_y > SL) m_y--; else m_scroll = 1;
          if (m_alt > m_score) m_score = m_alt;
        end
      end
      M_FALL: if (tk) begin
        if (hit != 0) begin m_ph = M_RISE; m_rise = 0; end
        else if (m_y >= FY) m_ph = M_OVER;
        else begin m_y++; if (m_alt > 0) m_alt--; end
      end
      M_OVER: if (ack) begin m_ph = M_IDLE; m_y = SY; end
    endcase
  endtask

  // One clock with the given inputs; returns 1 ns after the edge.
  task automatic step(input bit st, input bit ack, input bit tk,
                      input logic [3:0] hit);
    Start = st; Ack = ack; Tick = tk; plat_hit = hit;
    model_update(st, ack, tk, hit);
    @(posedge Clk); #1;
    Start = 0; Ack = 0; Tick = 0; plat_hit = '0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1, 4'b0000);
  endtask

  task automatic test_reset();
    Reset = 1; Start = 0; Ack = 0; Tick = 0; plat_hit = '0;
    s_start = 0; s_ack = 0; s_tick = 0; s_hit = '0;
    @(posedge Clk); #1;
    checks++;
    if ({q_I, q_Up, q_Down, q_Done} !== 4'b1000 || doodle_y !== 10'd440 ||
        score !== 16'd0 || scroll_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: q=%b y=%0d score=%0d scroll=%b, need q=1000 y=440 score=0 scroll=0",
               {q_I, q_Up, q_Down, q_Done}, doodle_y, score, scroll_en);
    end
    Reset = 0;
    model_reset();
  endtask

  task automatic test_simultaneous();
    step(1, 0, 1, 4'b0000);
    checks++;
    if (q_Up !== 1'b1 || doodle_y !== 10'd440 || score !== 16'd0) begin
      errors++;
      $display("FAIL start_with_tick: q_Up=%b y=%0d score=%0d, need 1 440 0", q_Up, doodle_y, score);
    end
    step(0, 0, 1, 4'b1111);
    checks++;
    if (q_Up !== 1'b1 || doodle_y !== 10'd439 || score !== 16'd1) begin
      errors++;
      $display("FAIL hit_ignored_in_up: q_Up=%b y=%0d score=%0d, need 1 439 1", q_Up, doodle_y, score);
    end
  endtask

  // Continues the game left by test_simultaneous, reaching y=300 mid-UP.
  task automatic test_mid_reset();
    ticks(119);
    step(0, 0, 1, 4'b0000);
    step(0, 0, 1, 4'b0100);
    ticks(20);
    checks++;
    if (q_Up !== 1'b1 || doodle_y !== 10'd300) begin
      errors++;
      $display("FAIL pre_reset_pos: q_Up=%b y=%0d, need 1 300", q_Up, doodle_y);
    end
    Reset = 1; #1;
    checks++;
    if ({q_I, q_Up, q_Down, q_Done} !== 4'b1000 || doodle_y !== 10'd440 ||
        score !== 16'd0 || scroll_en !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: q=%b y=%0d score=%0d scroll=%b, need 1000 440 0 0",
               {q_I, q_Up, q_Down, q_Done}, doodle_y, score, scroll_en);
    end
    #1 Reset = 0;
    model_reset();
    step(0, 0, 1, 4'b0000);
    checks++;
    if (q_I !== 1'b1 || doodle_y !== 10'd440) begin
      errors++;
      $display("FAIL post_reset_idle: q_I=%b y=%0d, need 1 440", q_I, doodle_y);
    end
  endtask

  task automatic test_apex();
    step(1, 0, 0, 4'b0000);
    checks++;
    if (q_Up !== 1'b1 || doodle_y !== 10'd440 || score !== 16'd0) begin
      errors++;
      $display("FAIL start_clears: q_Up=%b y=%0d score=%0d, need 1 440 0", q_Up, doodle_y, score);
    end
    ticks(1);
    checks++;
    if (doodle_y !== 10'd439) begin
      errors++;
      $display("FAIL first_pixel: y=%0d, need 439", doodle_y);
    end
    ticks(119);
    checks++;
    if (q_Up !== 1'b1 || doodle_y !== 10'd320 || score !== 16'd120) begin
      errors++;
      $display("FAIL apex: q_Up=%b y=%0d score=%0d, need 1 320 120", q_Up, doodle_y, score);
    end
    ticks(1);
    checks++;
    if (q_Down !== 1'b1 || doodle_y !== 10'd320) begin
      errors++;
      $display("FAIL apex_turn: q_Down=%b y=%0d, need 1 320", q_Down, doodle_y);
    end
  endtask

  task automatic test_fall();
    ticks(140);
    checks++;
    if (q_Down !== 1'b1 || doodle_y !== 10'd460) begin
      errors++;
      $display("FAIL floor_reach: q_Down=%b y=%0d, need 1 460", q_Down, doodle_y);
    end
    ticks(1);
    checks++;
    if (q_Done !== 1'b1 || score !== 16'd120 || doodle_y !== 10'd460) begin
      errors++;
      $display("FAIL game_over: q_Done=%b score=%0d y=%0d, need 1 120 460", q_Done, score, doodle_y);
    end
    ticks(3);
    checks++;
    if (q_Done !== 1'b1 || doodle_y !== 10'd460) begin
      errors++;
      $display("FAIL done_hold: q_Done=%b y=%0d, need 1 460", q_Done, doodle_y);
    end
    step(0, 1, 1, 4'b0000);
    checks++;
    if (q_I !== 1'b1 || doodle_y !== 10'd440 || score !== 16'd120) begin
      errors++;
      $display("FAIL ack: q_I=%b y=%0d score=%0d, need 1 440 120", q_I, doodle_y, score);
    end
  endtask

  task automatic test_bounce_scroll();
    step(1, 0, 0, 4'b0000);
    ticks(121);
    step(0, 0, 1, 4'b0010);
    checks++;
    if (q_Up !== 1'b1 || doodle_y !== 10'd320) begin
      errors++;
      $display("FAIL bounce: q_Up=%b y=%0d, need 1 320", q_Up, doodle_y);
    end
    for (int i = 0; i < 80; i++) begin
      step(0, 0, 1, 4'b0000);
      checks++;
      if (scroll_en !== 1'b0) begin
        errors++;
        $display("FAIL early_scroll: tick %0d scroll_en=%b, need 0", i, scroll_en);
      end
    end
    checks++;
    if (doodle_y !== 10'd240 || score !== 16'd200) begin
      errors++;
      $display("FAIL scroll_line: y=%0d score=%0d, need 240 200", doodle_y, score);
    end
    for (int i = 0; i < 40; i++) begin
      step(0, 0, 1, 4'b0000);
      checks++;
      if (scroll_en !== 1'b1 || doodle_y !== 10'd240) begin
        errors++;
        $display("FAIL scroll_pulse: tick %0d scroll_en=%b y=%0d, need 1 240", i, scroll_en, doodle_y);
      end
      step(0, 0, 0, 4'b0000);
      checks++;
      if (scroll_en !== 1'b0) begin
        errors++;
        $display("FAIL scroll_width: tick %0d scroll_en=%b, need 0", i, scroll_en);
      end
    end
    checks++;
    if (q_Up !== 1'b1 || score !== 16'd240) begin
      errors++;
      $display("FAIL scroll_score: q_Up=%b score=%0d, need 1 240", q_Up, score);
    end
    ticks(1);
    checks++;
    if (q_Down !== 1'b1 || doodle_y !== 10'd240 || scroll_en !== 1'b0) begin
      errors++;
      $display("FAIL scroll_apex: q_Down=%b y=%0d scroll=%b, need 1 240 0", q_Down, doodle_y, scroll_en);
    end
  endtask

  task automatic test_random();
    int mism;
    logic [3:0] h;
    Reset = 1; #2; Reset = 0;
    model_reset();
    mism = 0;
    for (int i = 0; i < 4000; i++) begin
      h = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      step($urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 1) == 1, h);
      checks++;
      if ({q_I, q_Up, q_Down, q_Done} !== exp_q(m_ph) || doodle_y !== 10'(m_y) ||
          score !== 16'(m_score) || scroll_en !== m_scroll) begin
        errors++;
        mism++;
        if (mism <= 10)
          $display("FAIL random cyc %0d: q=%b y=%0d score=%0d scroll=%b, model q=%b y=%0d score=%0d scroll=%b",
                   i, {q_I, q_Up, q_Down, q_Done}, doodle_y, score, scroll_en,
                   exp_q(m_ph), m_y, m_score, m_scroll);
      end
    end
  endtask

  task automatic test_saturation();
    s_start = 1; @(posedge Clk); #1; s_start = 0;
    for (int k = 1; k <= 20; k++) begin
      s_tick = 1; @(posedge Clk); #1; s_tick = 0;
      checks++;
      if (s_score !== 4'((k > 15) ? 15 : k) || s_y !== 10'(440 - k) || s_qu !== 1'b1) begin
        errors++;
        $display("FAIL sat_rise k=%0d: score=%0d y=%0d q_Up=%b, need %0d %0d 1",
                 k, s_score, s_y, s_qu, (k > 15) ? 15 : k, 440 - k);
      end
    end
    s_tick = 1; @(posedge Clk); #1; s_tick = 0;
    checks++;
    if (s_qd !== 1'b1 || s_score !== 4'd15 || s_y !== 10'd420) begin
      errors++;
      $display("FAIL sat_apex: q_Down=%b score=%0d y=%0d, need 1 15 420", s_qd, s_score, s_y);
    end
  endtask

  initial begin
    test_reset();
    test_simultaneous();
    test_mid_reset();
    test_apex();
    test_fall();
    test_bounce_scroll();
    test_random();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
